// File: rtl/mdu_ctrl_pkg.sv
// Shared types and encodings for the multiply/divide sequencer.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_MUL,
    MDU_DIV,
    MDU_FIX,
    MDU_DONE
  } mdu_state_t;

  localparam logic [6:0] FUNC7_MULDIV  = 7'b0000001;
  localparam int         DivIterations = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // DIV and REM treat their operands as two's complement.
  function automatic logic is_signed_div(input logic [2:0] func3);
    return (func3 == OP_DIV) || (func3 == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
module mdu_div_step #(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth:0]   rem_i,
  input  logic [DataWidth-1:0] quo_i,
  input  logic [DataWidth-1:0] divisor_i,
  output logic [DataWidth:0]   rem_o,
  output logic [DataWidth-1:0] quo_o
);

  logic [DataWidth+1:0] shifted;
  logic [DataWidth+1:0] trial;

  // Trial subtraction one bit wider than the remainder so the borrow is visible.
  always_comb begin
    shifted = {rem_i, quo_i[DataWidth-1]};
    trial   = shifted - {2'b00, divisor_i};
    if (trial[DataWidth+1]) begin
      rem_o = shifted[DataWidth:0];
      quo_o = {quo_i[DataWidth-2:0], 1'b0};
    end else begin
      rem_o = trial[DataWidth:0];
      quo_o = {quo_i[DataWidth-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M multi-cycle sequencer: registered multiply or 32-step restoring divide.
module mdu_ctrl #(
  parameter int DataWidth     = 32,
  parameter int DivIterations = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           func3_i,
  input  logic [DataWidth-1:0] rs1_i,
  input  logic [DataWidth-1:0] rs2_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] result_o
);
  import mdu_ctrl_pkg::*;

  localparam int CntW = $clog2(DivIterations);

  mdu_state_t           state_q, state_d;
  logic [2:0]           func3_q, func3_d;
  logic [DataWidth-1:0] a_q, a_d;        // multiplicand, or dividend/quotient
  logic [DataWidth-1:0] b_q, b_d;        // multiplier, or divisor magnitude
  logic [DataWidth:0]   rem_q, rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 qneg_q, qneg_d;  // quotient must be negated
  logic                 rneg_q, rneg_d;  // remainder takes negative sign
  logic [DataWidth-1:0] stage_q, stage_d;   // result waiting in DONE
  logic [DataWidth-1:0] result_q, result_d; // last retired result

  logic                   sgn_div;
  logic [DataWidth-1:0]   abs1, abs2;
  logic                   div_zero, div_ovf;
  logic                   mul_sa, mul_sb;
  logic [2*DataWidth-1:0] mul_a, mul_b, prod;
  logic [DataWidth:0]     step_rem;
  logic [DataWidth-1:0]   step_quo;
  logic [DataWidth-1:0]   quo_fix, rem_fix;

  mdu_div_step #(.DataWidth(DataWidth)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (a_q),
    .divisor_i (b_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand preparation, multiply datapath and sign fix-up.
  always_comb begin
    sgn_div  = is_signed_div(func3_i);
    abs1     = (sgn_div && rs1_i[DataWidth-1]) ? -rs1_i : rs1_i;
    abs2     = (sgn_div && rs2_i[DataWidth-1]) ? -rs2_i : rs2_i;
    div_zero = (rs2_i == '0);
    div_ovf  = sgn_div && (rs1_i == {1'b1, {(DataWidth-1){1'b0}}}) && (rs2_i == '1);
    mul_sa   = (func3_q != OP_MULHU);
    mul_sb   = (func3_q == OP_MUL) || (func3_q == OP_MULH);
    mul_a    = {{DataWidth{mul_sa & a_q[DataWidth-1]}}, a_q};
    mul_b    = {{DataWidth{mul_sb & b_q[DataWidth-1]}}, b_q};
    prod     = mul_a * mul_b;
    quo_fix  = qneg_q ? -a_q : a_q;
    rem_fix  = rneg_q ? -rem_q[DataWidth-1:0] : rem_q[DataWidth-1:0];
  end

  // Next-state and datapath register updates; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    func3_d  = func3_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    stage_d  = stage_q;
    result_d = result_q;
    if (flush_i) begin
      state_d = MDU_IDLE;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            func3_d = func3_i;
            a_d     = rs1_i;
            b_d     = rs2_i;
            if (!func3_i[2]) begin
              state_d = MDU_MUL;
            end else if (div_zero) begin
              stage_d = func3_i[1] ? rs1_i : '1;
              state_d = MDU_DONE;
            end else if (div_ovf) begin
              stage_d = func3_i[1] ? '0 : rs1_i;
              state_d = MDU_DONE;
            end else begin
              a_d     = abs1;
              b_d     = abs2;
              rem_d   = '0;
              cnt_d   = '0;
              qneg_d  = sgn_div && (rs1_i[DataWidth-1] ^ rs2_i[DataWidth-1]);
              rneg_d  = sgn_div && rs1_i[DataWidth-1];
              state_d = MDU_DIV;
            end
          end
        end
        MDU_MUL: begin
          stage_d = (func3_q == OP_MUL) ? prod[DataWidth-1:0]
                                        : prod[2*DataWidth-1:DataWidth];
          state_d = MDU_DONE;
        end
        MDU_DIV: begin
          rem_d = step_rem;
          a_d   = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DivIterations - 1)) begin
            state_d = MDU_FIX;
          end
        end
        MDU_FIX: begin
          stage_d = func3_q[1] ? rem_fix : quo_fix;
          state_d = MDU_DONE;
        end
        MDU_DONE: begin
          result_d = stage_q;
          state_d  = MDU_IDLE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      func3_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      stage_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func3_q  <= func3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      stage_q  <= stage_d;
      result_q <= result_d;
    end
  end

  // Outputs: the DONE cycle exposes the staged result directly unless flushed.
  always_comb begin
    busy_o   = (state_q != MDU_IDLE) && (state_q != MDU_DONE);
    stall_o  = ((state_q == MDU_IDLE) && start_i && !flush_i) || busy_o;
    done_o   = (state_q == MDU_DONE) && !flush_i;
    result_o = done_o ? stage_q : result_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: multiply, divide, special cases, flush and reset.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  func3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.DataWidth(32), .DivIterations(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .func3_i  (func3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op (start for cycle 0 only) and wait for done_o within a bound.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  cyc;
    bit  got;
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = f; rs1_i = a; rs2_i = b;
    @(negedge clk);
    chk({tag, "_stall_c0"}, {31'd0, stall_o}, 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
      @(negedge clk);
      if (done_o) got = 1'b1;
      else if (cyc == 1) chk({tag, "_stall_c1"}, {31'd0, stall_o}, 32'd1);
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int ndone;
    int dlat;
    logic [31:0] dres;

    rst = 1'b1; start_i = 1'b0; func3_i = 3'd0; rs1_i = '0; rs2_i = '0; flush_i = 1'b0;
    #12;
    chk("rst_result", result_o, 32'd0);
    chk("rst_flags", {28'd0, stall_o, busy_o, done_o, 1'b0}, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("mul",    3'b000, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    do_op("mulh",   3'b001, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 2);
    do_op("mulhu",  3'b011, 32'h7, 32'hFFFFFFFD, 32'h00000006, 2);
    do_op("mulhsu", 3'b010, 32'h7, 32'hFFFFFFFD, 32'h00000006, 2);
    do_op("div",    3'b100, 32'hFFFFFFEC, 32'h3, 32'hFFFFFFFA, 34);
    do_op("rem",    3'b110, 32'hFFFFFFEC, 32'h3, 32'hFFFFFFFE, 34);
    do_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu",   3'b111, 32'd100, 32'd7, 32'd2, 34);
    do_op("div_neg_divisor", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
    do_op("divu_big", 3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);
    do_op("divu_z", 3'b101, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
    do_op("rem_z",  3'b110, 32'h1234, 32'h0, 32'h00001234, 1);
    do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Flush during the divide loop: prior result (0) must survive.
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_no_done", {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle", {30'd0, busy_o, stall_o}, 32'd0);
    chk("flush_result", result_o, 32'd0);
    do_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 2);

    // Flush and start in the same cycle: nothing accepted.
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; func3_i = 3'b101; rs1_i = 32'd9; rs2_i = 32'd2;
    @(negedge clk);
    chk("flush_start_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_start_result", result_o, 32'd12);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = 3'b100; rs1_i = 32'd50; rs2_i = 32'd5;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_result", result_o, 32'd0);
    chk("arst_flags", {29'd0, stall_o, busy_o, done_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // start_i held high while busy must not launch a second op.
    @(posedge clk); #1;
    start_i = 1'b1; func3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7;
    ndone = 0; dlat = -1; dres = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) begin
        ndone++;
        dlat = c;
        dres = result_o;
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("busy_ndone", ndone, 32'd1);
    chk("busy_lat", dlat, 32'd34);
    chk("busy_res", dres, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
